// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined adder family: slice width and configuration check.
// Optional signed-overflow output is enabled with PIPELINED_ADDER_OVF_EN.
package adder_pkg;

   localparam int DEF_WIDTH  = 16;
   localparam int DEF_STAGES = 4;

   function automatic int slice_width(input int width, input int stages);
      return (stages >= 1) ? (width / stages) : 0;
   endfunction

   function automatic bit cfg_ok(input int width, input int stages);
      return (stages >= 1) && ((width % stages) == 0);
   endfunction

endpackage

// File: rtl/adder_slice.sv
// CW-bit combinational ripple-carry slice built from full_adder cells.
// With PIPELINED_ADDER_OVF_EN defined it also exposes the carry into its MSB.
module adder_slice #(
   parameter int CW = 4
) (
   input  logic [CW-1:0] a,
   input  logic [CW-1:0] b,
   input  logic          cin,
   output logic [CW-1:0] s,
   output logic          cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,output logic          cmsb
`endif
);

   logic [CW:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CW; i++) begin : g_bit
      full_adder u_fa (
         .a    (a[i]),
         .b    (b[i]),
         .cin  (c[i]),
         .s    (s[i]),
         .cout (c[i+1])
      );
   end

   assign cout = c[CW];
`ifdef PIPELINED_ADDER_OVF_EN
   assign cmsb = c[CW-1];
`endif

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple slices.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: one CW-bit slice per stage, carry registered between stages.
// Define PIPELINED_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,output logic             ovf
`endif
);

   localparam int CW = slice_width(WIDTH, STAGES);

   if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
   end

   // Handshake: a word moves on valid&ready at a rising edge. The whole pipe advances
   // together when the output slot is empty or being drained; in_ready never looks at in_valid.
   logic adv;
   assign adv      = !out_valid || out_ready;
   assign in_ready = adv;

   logic             vld_q  [STAGES];
   logic             cy_q   [STAGES];
   logic [WIDTH-1:0] sum_q  [STAGES];
   logic [WIDTH-1:0] opa_q  [STAGES];
   logic [WIDTH-1:0] opb_q  [STAGES];
   logic             cout_w [STAGES];
`ifdef PIPELINED_ADDER_OVF_EN
   logic             cmsb_w [STAGES];
`endif

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] a_in, b_in, s_in, s_nxt;
      logic             c_in, v_in;
      logic [CW-1:0]    s_slice;

      // Stage 0 reads the ports; later stages read the skewed operands and partial sums.
      if (k == 0) begin : g_first
         assign a_in = a;
         assign b_in = b;
         assign s_in = '0;
         assign c_in = cin;
         assign v_in = in_valid;
      end else begin : g_next
         assign a_in = opa_q[k-1];
         assign b_in = opb_q[k-1];
         assign s_in = sum_q[k-1];
         assign c_in = cy_q[k-1];
         assign v_in = vld_q[k-1];
      end

      adder_slice #(.CW(CW)) u_slice (
         .a    (a_in[k*CW +: CW]),
         .b    (b_in[k*CW +: CW]),
         .cin  (c_in),
         .s    (s_slice),
         .cout (cout_w[k])
`ifdef PIPELINED_ADDER_OVF_EN
        ,.cmsb (cmsb_w[k])
`endif
      );

      always_comb begin
         s_nxt              = s_in;
         s_nxt[k*CW +: CW]  = s_slice;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q[k] <= 1'b0;
            cy_q[k]  <= 1'b0;
            sum_q[k] <= '0;
            opa_q[k] <= '0;
            opb_q[k] <= '0;
         end else if (adv) begin
            vld_q[k] <= v_in;
            cy_q[k]  <= cout_w[k];
            sum_q[k] <= s_nxt;
            opa_q[k] <= a_in;
            opb_q[k] <= b_in;
         end
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign s         = sum_q[STAGES-1];
   assign cout      = cy_q[STAGES-1];

`ifdef PIPELINED_ADDER_OVF_EN
   logic ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (adv) begin
         ovf_q <= cmsb_w[STAGES-1] ^ cout_w[STAGES-1];
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, STAGES=4) with directed vectors.
// Also checks ovf when built with PIPELINED_ADDER_OVF_EN.
module tb_pipelined_adder;

   localparam int WIDTH  = 16;
   localparam int STAGES = 4;
   localparam int W      = WIDTH + 2;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] s;
      logic        cout;
      logic        ovf;
   } vec_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
`ifdef PIPELINED_ADDER_OVF_EN
   logic             ovf;
`endif

   vec_t          vecs [16];
   logic [W-1:0]  exp_q [$];
   logic [W-1:0]  e;
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            acc_cyc = 0;
   int            out_cyc = 0;
   int            tx_cnt = 0;
   int            rx_cnt = 0;
   bit            mon_en = 1'b0;
   bit            bp_en = 1'b0;
   bit            stall_prev = 1'b0;
   logic [WIDTH-1:0] prev_s;
   logic          prev_cout;

   pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .cout      (cout)
`ifdef PIPELINED_ADDER_OVF_EN
     ,.ovf       (ovf)
`endif
   );

   // clock/reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      if (bp_en) begin
         #1 out_ready = 1'($urandom_range(0, 1));
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // driver tasks
   task automatic send_op(input int idx, input bit gaps);
      int  n = 0;
      bit  got = 1'b0;
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b1;
      a        = vecs[idx].a;
      b        = vecs[idx].b;
      cin      = vecs[idx].cin;
      while (!got && n < 200) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1'b1;
            acc_cyc = cyc;
            exp_q.push_back({vecs[idx].ovf, vecs[idx].cout, vecs[idx].s});
            tx_cnt++;
         end else begin
            @(posedge clk); #1;
         end
         n++;
      end
      check("accept", 32'(got), 32'd1);
   endtask

   task automatic go_idle();
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // scoreboard / monitor
   always @(negedge clk) begin
      if (mon_en) begin
         check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
         if (stall_prev) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_s", 32'(s), 32'(prev_s));
            check("stall_cout", 32'(cout), 32'(prev_cout));
         end
         if (out_valid && out_ready) begin
            rx_cnt++;
            out_cyc = cyc;
            check("out_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("sum", 32'(s), 32'(e[15:0]));
               check("cout", 32'(cout), 32'(e[16]));
`ifdef PIPELINED_ADDER_OVF_EN
               check("ovf", 32'(ovf), 32'(e[17]));
`endif
            end
         end
         stall_prev = out_valid && !out_ready;
         prev_s     = s;
         prev_cout  = cout;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, rx0, lat, stale;
      //          a         b         cin   s         cout  ovf
      vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
      vecs[1]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[2]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[3]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
      vecs[4]  = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[5]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[6]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[7]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      vecs[8]  = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};
      vecs[9]  = '{16'hF0F0, 16'h0F0F, 1'b0, 16'hFFFF, 1'b0, 1'b0};
      vecs[10] = '{16'hF0F0, 16'h0F0F, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[11] = '{16'h1357, 16'h9BDF, 1'b0, 16'hAF36, 1'b0, 1'b0};
      vecs[12] = '{16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[13] = '{16'h4000, 16'h4000, 1'b1, 16'h8001, 1'b0, 1'b1};
      vecs[14] = '{16'hC000, 16'hC000, 1'b0, 16'h8000, 1'b1, 1'b0};
      vecs[15] = '{16'h5A5A, 16'hA5A5, 1'b1, 16'h0000, 1'b1, 1'b0};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; cin = 1'b0;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_s", 32'(s), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      mon_en = 1'b1;

      // single op and its latency
      send_op(0, 1'b0);
      go_idle();
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 50);
      check("latency", 32'(lat), 32'(STAGES));
      wait_drain(20);

      // carry through every slice and other boundary vectors
      for (int i = 1; i <= 7; i++) send_op(i, 1'b0);
      go_idle();
      wait_drain(30);

      // back-to-back streaming at full rate
      rx0 = rx_cnt;
      t0 = 0;
      for (int i = 0; i < 16; i++) begin
         send_op(i, 1'b0);
         if (i == 0) t0 = acc_cyc;
      end
      go_idle();
      wait_drain(40);
      check("stream_accept_span", 32'(acc_cyc - t0), 32'd15);
      check("stream_out_count", 32'(rx_cnt - rx0), 32'd16);
      check("stream_last_latency", 32'(out_cyc - acc_cyc), 32'(STAGES));

      // random backpressure with gaps on the input
      bp_en = 1'b1;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 16; i++) send_op(i, 1'b1);
      end
      go_idle();
      bp_en = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      wait_drain(100);
      check("rx_total", 32'(rx_cnt), 32'(tx_cnt));

      // reset with work in flight
      mon_en = 1'b0;
      for (int i = 0; i < 3; i++) send_op(i, 1'b0);
      go_idle();
      @(posedge clk); #1;
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_s", 32'(s), 32'd0);
      check("midrst_cout", 32'(cout), 32'd0);
      tx_cnt = tx_cnt - exp_q.size();
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      stale = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) stale++;
      end
      check("no_stale", 32'(stale), 32'd0);
      mon_en = 1'b1;
      send_op(8, 1'b0);
      go_idle();
      wait_drain(20);
      check("rx_after_rst", 32'(rx_cnt), 32'(tx_cnt));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
